// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a programmable integer clock divider.
// It starts and stops a divided clock only on period boundaries. Ratio changes
// come in through a valid/ready handshake and are held as a pending ratio. A
// pending ratio takes effect at the next period boundary, or immediately when
// the divider is idle. The block produces a registered divided clock and a
// one-cycle tick in the last cycle of each period.
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_vld;
  logic             r_clk_out;
  logic             r_cfg_err;

  logic             w_busy;
  logic             w_term;
  logic             w_xfer;
  logic             w_legal;
  logic             w_apply;
  logic [DIV_W-1:0] w_next_div;
  logic [DIV_W-1:0] w_next_cnt;
  logic             w_next_high;

  // The high phase is the larger half, so odd ratios get the extra cycle high.
  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] n);
    return n - (n >> 1);
  endfunction

  assign w_busy  = (r_state != S_IDLE);
  assign w_term  = w_busy && (r_cnt == r_cur_div - DIV_W'(1));
  assign w_xfer  = cfg_valid && !r_pend_vld;
  assign w_legal = (cfg_div >= DIV_W'(2));
  // A ratio captured in a terminal cycle is not yet pending. It therefore
  // waits for the following boundary.
  assign w_apply = r_pend_vld && ((r_state == S_IDLE) || w_term);

  assign w_next_div  = w_apply ? r_pend_div : r_cur_div;
  assign w_next_cnt  = w_term ? '0 : r_cnt + DIV_W'(1);
  assign w_next_high = (w_next_cnt < high_len(w_next_div));

  // Run/stop sequencing, period counter and registered divided clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (en) begin
            r_state   <= S_RUN;
            r_clk_out <= 1'b1;
          end else begin
            r_clk_out <= 1'b0;
          end
        end
        S_RUN, S_STOP: begin
          // With en low in a terminal cycle, the current period is the last.
          if (w_term && !en) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
          end else begin
            r_state   <= en ? S_RUN : S_STOP;
            r_cnt     <= w_next_cnt;
            r_clk_out <= w_next_high;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
        end
      endcase
    end
  end

  // Ratio handshake, the pending slot, and the hand-over to the active ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_div  <= DIV_W'(DEFAULT_DIV);
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !w_legal;
      if (w_apply) begin
        r_cur_div  <= r_pend_div;
        r_pend_vld <= 1'b0;
      end else if (w_xfer && w_legal) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

  // The pending ratio is only meaningful while r_pend_vld is set.
  always_ff @(posedge clk) begin
    if (w_xfer && w_legal) begin
      r_pend_div <= cfg_div;
    end
  end

  assign cfg_ready = !r_pend_vld;
  assign cfg_err   = r_cfg_err;
  assign clk_out   = r_clk_out;
  assign tick      = w_term;
  assign busy      = w_busy;
  assign cur_div   = r_cur_div;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl. An independent cycle model
// predicts the outputs. Each prediction is queued when the stimulus is driven
// and is compared once the DUT has registered that cycle.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_div;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       ready;
    logic       err;
    logic [7:0] div;
  } exp_t;

  exp_t q[$];

  // Model state: m_st is 0 for idle, 1 for run and 2 for stopping.
  int m_st, m_cnt, m_div, m_pend, m_pvld, m_clk, m_err;

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_div = 2; m_pvld = 0; m_clk = 0; m_err = 0; m_pend = 0;
  endtask

  // Advance the model by one clock edge, using the inputs seen before that edge.
  task automatic model_step(input logic r, input logic e, input logic v, input int d);
    bit term, xfer, apply;
    int ndiv;
    if (r) begin
      model_reset();
      return;
    end
    term  = (m_st != 0) && (m_cnt == m_div - 1);
    xfer  = v && (m_pvld == 0);
    apply = (m_pvld != 0) && (m_st == 0 || term);
    m_err = (xfer && d < 2) ? 1 : 0;
    ndiv  = apply ? m_pend : m_div;
    if (apply) m_pvld = 0;
    else if (xfer && d >= 2) begin m_pvld = 1; m_pend = d; end
    m_div = ndiv;
    if (m_st == 0) begin
      m_cnt = 0;
      m_st  = e ? 1 : 0;
      m_clk = e ? 1 : 0;
    end else if (term && !e) begin
      m_st = 0; m_cnt = 0; m_clk = 0;
    end else begin
      m_cnt = term ? 0 : m_cnt + 1;
      m_st  = e ? 1 : 2;
      m_clk = (m_cnt < (m_div + 1) / 2) ? 1 : 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.clk_out = m_clk[0];
    x.tick    = (m_st != 0) && (m_cnt == m_div - 1);
    x.busy    = (m_st != 0);
    x.ready   = (m_pvld == 0);
    x.err     = m_err[0];
    x.div     = m_div[7:0];
    return x;
  endfunction

  // Drive one cycle of stimulus and queue its prediction, then compare the
  // DUT just after the edge.
  task automatic step(input logic r, input logic e, input logic v, input int d);
    exp_t x;
    rst = r; en = e; cfg_valid = v; cfg_div = d[7:0];
    model_step(r, e, v, d);
    q.push_back(model_out());
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      x = q.pop_front();
      chk("clk_out", clk_out, x.clk_out);
      chk("tick", tick, x.tick);
      chk("busy", busy, x.busy);
      chk("cfg_ready", cfg_ready, x.ready);
      chk("cfg_err", cfg_err, x.err);
      chk("cur_div", cur_div, x.div);
    end
  endtask

  // Run with en=e until the model reaches the given ratio and count.
  // Running out of budget is reported as a failed comparison.
  task automatic run_until(input string tag, input logic e, input int div, input int cnt, input int budget);
    int n = 0;
    while (!(m_div == div && m_cnt == cnt && m_st != 0) && n < budget) begin
      step(1'b0, e, 1'b0, 0);
      n++;
    end
    chk(tag, (m_div == div && m_cnt == cnt) ? 1 : 0, 1);
  endtask

  initial begin
    model_reset();
    // Reset state
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_div", cur_div, 8'd2);

    // 1: default ratio 2 toggles every cycle
    step(1'b0, 1'b1, 1'b0, 0);
    chk("t1_first_high", clk_out, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("t1_low", clk_out, 1'b0);
    chk("t1_tick", tick, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
    chk("t1_stopped", busy, 1'b0);

    // 2: ratio 3 loaded while idle, then run
    step(1'b0, 1'b0, 1'b1, 3);
    chk("t2_pending", cfg_ready, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t2_cur_div", cur_div, 8'd3);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 0);

    // 3: switch to 5, then offer 4 at cnt=1
    step(1'b0, 1'b1, 1'b1, 5);
    run_until("t3_reach5", 1'b1, 5, 1, 20);
    step(1'b0, 1'b1, 1'b1, 4);
    chk("t3_ready_low", cfg_ready, 1'b0);
    chk("t3_still5", cur_div, 8'd5);
    run_until("t3_reach4", 1'b1, 4, 0, 10);
    chk("t3_cur4", cur_div, 8'd4);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0);

    // 4: illegal ratios 0 and 1 are rejected
    step(1'b0, 1'b1, 1'b1, 0);
    chk("t4_err0", cfg_err, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("t4_err_clear", cfg_err, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1);
    chk("t4_err1", cfg_err, 1'b1);
    chk("t4_div_kept", cur_div, 8'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 0);

    // 5: ratio 6, stop requested at cnt=2, then a resume at cnt=4
    step(1'b0, 1'b1, 1'b1, 6);
    run_until("t5_reach6", 1'b1, 6, 2, 20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
    chk("t5_still_busy", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t5_idle", busy, 1'b0);
    chk("t5_clk_low", clk_out, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0);
    run_until("t5_cnt2", 1'b1, 6, 2, 10);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      chk("t5_no_gap", busy, 1'b1);
    end

    // Largest ratio: the counter reaches 254 and wraps cleanly
    step(1'b0, 1'b1, 1'b1, 255);
    run_until("max_reach", 1'b1, 255, 254, 300);
    chk("max_tick", tick, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("max_wrap_high", clk_out, 1'b1);

    // 6: reset mid-run with a ratio pending
    step(1'b0, 1'b1, 1'b1, 7);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("t6_ready", cfg_ready, 1'b1);
    chk("t6_div", cur_div, 8'd2);
    chk("t6_busy", busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t6_stays2", cur_div, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
